// File: rtl/inpkt_header_parser.sv
// Input packet parser: strips and checks the 14-byte header and 4-byte trailer, forwards
// body bytes with flow control. Any error is sticky and stops all further FIFO reads.
module inpkt_header_parser #(
   parameter int unsigned VERSION          = 2,
   parameter int unsigned PKT_TYPE_MAX     = 3,
   parameter int unsigned PKT_MAX_LEN      = 65536,
   parameter bit          DISABLE_CHECKSUM = 1'b0
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        empty,
   output logic        rd_en,
   output logic [7:0]  pkt_type,
   output logic [15:0] pkt_id,
   output logic [23:0] pkt_len,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_rd_en,
   output logic        out_end,
   output logic        pkt_done,
   output logic        err_version,
   output logic        err_type,
   output logic        err_len,
   output logic        err_checksum
);

   typedef enum logic [2:0] {StHdr, StHdrChk, StHcsum, StBody, StBcsum, StErr} state_e;

   state_e      state_q;
   logic [23:0] cnt_q;
   logic [31:0] acc_q;
   logic [31:0] csum_rx_q;
   logic [7:0]  ver_q;

   logic        last_body;
   logic [31:0] lane_add;
   logic [31:0] csum_word;
   logic        csum_ok;
   logic        bad_ver, bad_type, bad_len;

   always_comb begin
      out_valid = (state_q == StBody) && !empty;
      case (state_q)
         StHdr, StHcsum, StBcsum: rd_en = !empty;
         StBody:                  rd_en = out_valid && out_rd_en;
         default:                 rd_en = 1'b0;
      endcase
      last_body = (cnt_q == pkt_len - 24'd1);
      out_end   = out_valid && last_body;
      out_data  = (state_q == StBody) ? din : 8'h00;
      // Adding each byte into its little-endian lane equals summing zero-padded words.
      lane_add  = {24'h000000, din} << {cnt_q[1:0], 3'b000};
      // Trailer bytes arrive LSB first; this is the full word once the 4th byte is on din.
      csum_word = {din, csum_rx_q[31:8]};
      csum_ok   = DISABLE_CHECKSUM || (csum_word == ~acc_q);
      bad_ver   = {24'h000000, ver_q} != VERSION;
      bad_type  = (pkt_type == 8'h00) || ({24'h000000, pkt_type} > PKT_TYPE_MAX);
      bad_len   = (pkt_len == 24'h000000) || ({8'h00, pkt_len} > PKT_MAX_LEN);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q      <= StHdr;
         cnt_q        <= '0;
         acc_q        <= '0;
         csum_rx_q    <= '0;
         ver_q        <= '0;
         pkt_type     <= '0;
         pkt_id       <= '0;
         pkt_len      <= '0;
         pkt_done     <= 1'b0;
         err_version  <= 1'b0;
         err_type     <= 1'b0;
         err_len      <= 1'b0;
         err_checksum <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (state_q)
            StHdr: if (rd_en) begin
               acc_q <= acc_q + lane_add;
               case (cnt_q[3:0])
                  4'd0:    ver_q          <= din;
                  4'd1:    pkt_type       <= din;
                  4'd4:    pkt_len[7:0]   <= din;
                  4'd5:    pkt_len[15:8]  <= din;
                  4'd6:    pkt_len[23:16] <= din;
                  4'd8:    pkt_id[7:0]    <= din;
                  4'd9:    pkt_id[15:8]   <= din;
                  default: ;
               endcase
               if (cnt_q == 24'd9) begin
                  cnt_q   <= '0;
                  state_q <= StHdrChk;
               end else begin
                  cnt_q <= cnt_q + 24'd1;
               end
            end
            StHdrChk: begin
               err_version <= bad_ver;
               err_type    <= bad_type;
               err_len     <= bad_len;
               state_q     <= (bad_ver || bad_type || bad_len) ? StErr : StHcsum;
            end
            StHcsum: if (rd_en) begin
               csum_rx_q <= csum_word;
               if (cnt_q == 24'd3) begin
                  cnt_q <= '0;
                  if (csum_ok) begin
                     acc_q   <= '0;
                     state_q <= StBody;
                  end else begin
                     err_checksum <= 1'b1;
                     state_q      <= StErr;
                  end
               end else begin
                  cnt_q <= cnt_q + 24'd1;
               end
            end
            StBody: if (rd_en) begin
               acc_q <= acc_q + lane_add;
               if (last_body) begin
                  cnt_q   <= '0;
                  state_q <= StBcsum;
               end else begin
                  cnt_q <= cnt_q + 24'd1;
               end
            end
            StBcsum: if (rd_en) begin
               csum_rx_q <= csum_word;
               if (cnt_q == 24'd3) begin
                  cnt_q <= '0;
                  acc_q <= '0;
                  if (csum_ok) begin
                     pkt_done <= 1'b1;
                     state_q  <= StHdr;
                  end else begin
                     err_checksum <= 1'b1;
                     state_q      <= StErr;
                  end
               end else begin
                  cnt_q <= cnt_q + 24'd1;
               end
            end
            StErr:   ;
            default: state_q <= StErr;
         endcase
      end
   end

endmodule
